wb_sequencer: RTL
=================

Name: wb_sequencer

Overview:
Multi-cycle writeback controller for the register-file write port. It drives maluandmem_ctr on the ALU/memory writeback mux and supplies that mux's mem_data input. It sequences load requests and responses on a handshaked data-memory port, aligns and extends load data, and stalls the datapath until each instruction's writeback completes.

Parameters:
TIMEOUT_CYCLES, 16, MEM_WAIT cycles before a forced completion (used only with WB_TIMEOUT_EN).
CTR_IDLE, 3'b000, value driven on maluandmem_ctr outside writeback states.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decoded instruction present
issue_ready  output  1  sequencer can accept (state IDLE)
issue_wb_sel  input  3  writeback source: 3'b001 = load/memory, any other code = non-load, forwarded unchanged to maluandmem_ctr
issue_wb_en  input  1  instruction writes rd
issue_rd  input  5  destination register
issue_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
issue_addr_lo  input  2  load byte address [1:0]
mem_req_valid  output  1  load request to data memory
mem_req_ready  input  1  memory accepts request
mem_rsp_valid  input  1  load data valid
mem_rsp_data  input  32  raw aligned word
maluandmem_ctr  output  3  writeback mux select
mem_data  output  32  extended load data to mux
rf_we  output  1  register-file write enable
rf_waddr  output  5  register-file write address
stall  output  1  hold PC/decode/ALU operands
mem_timeout  output  1  one-cycle pulse on forced completion (0 without macro)

Behaviour:
- Reset (async, rst_n=0): state IDLE. Outputs: issue_ready=1, mem_req_valid=0, rf_we=0, rf_waddr=0, maluandmem_ctr=CTR_IDLE, mem_data=0, mem_timeout=0. Reset mid-load abandons the request. A later mem_rsp_valid is ignored in IDLE.
- States: IDLE, WB_ALU, MEM_REQ, MEM_WAIT, WB_MEM. Moore outputs, except stall.
- IDLE: issue_ready=1. On issue_valid, latch wb_sel, wb_en, rd, funct3, addr_lo. If wb_sel==3'b001, go to MEM_REQ; otherwise go to WB_ALU.
- stall = (state!=IDLE && state not in {WB_ALU, WB_MEM}) || (state==IDLE && issue_valid). The datapath holds ALU_result stable while stall=1.
- WB_ALU: maluandmem_ctr=latched wb_sel, rf_we=wb_en && rd!=0, rf_waddr=rd, stall=0, then IDLE. A non-load takes 2 cycles from accept to retire.
- MEM_REQ: mem_req_valid=1, held until mem_req_ready. Move to MEM_WAIT on the handshake. If mem_rsp_valid is also high in that cycle, capture the data and go directly to WB_MEM.
- MEM_WAIT: on mem_rsp_valid, capture the extended data into mem_data and go to WB_MEM.
- WB_MEM: maluandmem_ctr=3'b001, rf_we=wb_en && rd!=0, stall=0, then IDLE. Minimum load latency is 3 cycles after accept.
- Extension: LB/LBU select byte addr_lo and sign-/zero-extend it. LH/LHU select halfword addr_lo[1] (addr_lo[0] ignored) and sign-/zero-extend it. LW and any other funct3 pass the word through.
- mem_data holds its value until the next load capture. In IDLE and WB_ALU, maluandmem_ctr=CTR_IDLE except where stated above.
- Writes to rd=0 are always suppressed (rf_we=0), while the sequence still completes.

Optional Feature:
WB_TIMEOUT_EN:
- Defined: a counter runs in MEM_WAIT. When TIMEOUT_CYCLES elapse with no response, the sequencer goes to WB_MEM with mem_data=0 and pulses mem_timeout for 1 cycle. The counter clears on entering MEM_WAIT and on reset.
- Undefined: the sequencer waits indefinitely, and mem_timeout is tied to 0.

Test Plan:
- ALU op: wb_sel=000, rd=5, wb_en=1, ALU_result=1 → stall=1 for 1 cycle; next cycle rf_we=1, rf_waddr=5, ctr=000, stall=0.
- LW: mem_req_ready on the first cycle, response 0x00000002 two cycles later → mem_data=0x00000002, ctr=001, rf_we=1 in WB_MEM.
- LB addr_lo=3, rsp=0x80123456 → mem_data=0xFFFFFF80. LBU → 0x00000080. LHU addr_lo=2 → 0x00008012.
- Back-pressure: mem_req_ready low for 4 cycles → mem_req_valid stays 1 and stall=1 throughout. rd=0 → rf_we never asserts.
- Reset asserted in MEM_WAIT, then a late mem_rsp_valid → all outputs at reset values, response ignored, next issue accepted normally.
- With WB_TIMEOUT_EN, no response → after 16 MEM_WAIT cycles, mem_timeout=1 for 1 cycle, rf_we=1, mem_data=0.

Source files
------------

// File: rtl/wb_sequencer.sv
// Writeback sequencer: drives the ALU/memory writeback mux and sequences handshaked loads with alignment/extension.
// Latency: non-load retires 2 cycles after accept, load at least 3; optional WB_TIMEOUT_EN forces load completion.
// Backpressure: issue_ready only in IDLE; mem_req_valid held until mem_req_ready; stall holds the datapath meanwhile.
module wb_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  CTR_IDLE       = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_wb_sel,
    input  logic        issue_wb_en,
    input  logic [4:0]  issue_rd,
    input  logic [2:0]  issue_funct3,
    input  logic [1:0]  issue_addr_lo,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [2:0]  maluandmem_ctr,
    output logic [31:0] mem_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic        stall,
    output logic        mem_timeout
);

    localparam logic [2:0] SEL_MEM = 3'b001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WB_ALU   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        WB_MEM   = 3'd4
    } state_t;

    state_t      state;
    logic        wb_en_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rsp_ext;
    logic        wr_ok;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b100:  extend = {24'd0, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b101:  extend = {16'd0, h};
            default: extend = w;
        endcase
    endfunction

    assign rsp_ext = extend(mem_rsp_data, funct3_q, addr_lo_q);
    assign wr_ok   = wb_en_q && (rd_q != 5'd0);

    // Writeback states let the datapath advance; everything else outside IDLE holds it.
    assign stall = (state == IDLE) ? issue_valid : !(state == WB_ALU || state == WB_MEM);

`ifdef WB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt;
`else
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            issue_ready    <= 1'b1;
            mem_req_valid  <= 1'b0;
            rf_we          <= 1'b0;
            rf_waddr       <= 5'd0;
            maluandmem_ctr <= CTR_IDLE;
            mem_data       <= 32'd0;
            wb_en_q        <= 1'b0;
            rd_q           <= 5'd0;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 2'd0;
`ifdef WB_TIMEOUT_EN
            wait_cnt       <= '0;
            mem_timeout    <= 1'b0;
`endif
        end else begin
            // Outputs are registered for the state being entered; defaults describe the non-writeback view.
            issue_ready    <= 1'b0;
            mem_req_valid  <= 1'b0;
            rf_we          <= 1'b0;
            rf_waddr       <= 5'd0;
            maluandmem_ctr <= CTR_IDLE;
`ifdef WB_TIMEOUT_EN
            mem_timeout    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    issue_ready <= 1'b1;
                    if (issue_valid) begin
                        wb_en_q     <= issue_wb_en;
                        rd_q        <= issue_rd;
                        funct3_q    <= issue_funct3;
                        addr_lo_q   <= issue_addr_lo;
                        issue_ready <= 1'b0;
                        if (issue_wb_sel == SEL_MEM) begin
                            state         <= MEM_REQ;
                            mem_req_valid <= 1'b1;
                        end else begin
                            state          <= WB_ALU;
                            maluandmem_ctr <= issue_wb_sel;
                            rf_we          <= issue_wb_en && (issue_rd != 5'd0);
                            rf_waddr       <= issue_rd;
                        end
                    end
                end
                WB_ALU: begin
                    state       <= IDLE;
                    issue_ready <= 1'b1;
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        if (mem_rsp_valid) begin
                            state          <= WB_MEM;
                            mem_data       <= rsp_ext;
                            maluandmem_ctr <= SEL_MEM;
                            rf_we          <= wr_ok;
                            rf_waddr       <= rd_q;
                        end else begin
                            state <= MEM_WAIT;
`ifdef WB_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end else begin
                        mem_req_valid <= 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        state          <= WB_MEM;
                        mem_data       <= rsp_ext;
                        maluandmem_ctr <= SEL_MEM;
                        rf_we          <= wr_ok;
                        rf_waddr       <= rd_q;
`ifdef WB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_LAST) begin
                        state          <= WB_MEM;
                        mem_data       <= 32'd0;
                        maluandmem_ctr <= SEL_MEM;
                        rf_we          <= wr_ok;
                        rf_waddr       <= rd_q;
                        mem_timeout    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                WB_MEM: begin
                    state       <= IDLE;
                    issue_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    issue_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
